core_run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle RV32I core.
- Holds the core in reset while a host loads program words into instruction memory.
- Releases reset, then runs, single-steps or halts the core through a clock-enable.
- Stops on EBREAK, on a host halt request or on an optional PC breakpoint.
- Sits between the host/debug port and the core top level; drives the core's `rst`, a clock-enable into PC/register-file/data-memory write paths, and the instruction-memory write port.

---
 rtl/core_run_ctrl_pkg.sv | 43 ++++
 rtl/core_run_ctrl_if.sv | 70 +++++++
 rtl/core_run_ctrl_sat_counter.sv | 34 +++
 rtl/core_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_core_run_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_run_ctrl_pkg.sv
// ============================================================================
//  Module   : core_run_ctrl_pkg
//  Purpose  : Shared types and constants for the RV32I run-control sequencer:
//             FSM state encoding, halt-cause codes and the EBREAK encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_run_ctrl_pkg;

    // Data/address width of the host load port and the core PC/instruction bus
    localparam int c_XLEN = 32;

    // Instruction word of EBREAK, the software stop request
    localparam logic [c_XLEN-1:0] c_EBREAK_INSN = 32'h0010_0073;

    // Sequencer state encoding, also exported on the state output
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CRST   = 3'd2,
        ST_HALTED = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5
    } run_state_t;

    // Reason the core last entered HALTED
    typedef enum logic [2:0] {
        CAUSE_RESET  = 3'd0,
        CAUSE_HOST   = 3'd1,
        CAUSE_EBREAK = 3'd2,
        CAUSE_BKPT   = 3'd3,
        CAUSE_STEP   = 3'd4
    } halt_cause_t;

    // True when the fetched word is EBREAK
    function automatic logic is_ebreak(input logic [c_XLEN-1:0] insn);
        return insn == c_EBREAK_INSN;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_run_ctrl_if.sv
// ============================================================================
//  Module   : core_run_ctrl_if
//  Purpose  : Host/debug and core-side signal bundle of the run-control
//             sequencer. The breakpoint signals exist only when the macro
//             CORE_RUN_CTRL_BKPT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_run_ctrl_if
    import core_run_ctrl_pkg::*;
#(
    parameter int CYC_W = 32
);
    // Program-load port
    logic              ld_valid;
    logic              ld_ready;
    logic [c_XLEN-1:0] ld_addr;
    logic [c_XLEN-1:0] ld_data;
    logic              ld_last;
    // Host command pulses
    logic              cmd_run;
    logic              cmd_step;
    logic              cmd_halt;
    // Core observation
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] instr;
`ifdef CORE_RUN_CTRL_BKPT_EN
    logic              bkpt_en;
    logic [c_XLEN-1:0] bkpt_addr;
`endif
    // Instruction-memory write port
    logic              imem_we;
    logic [c_XLEN-1:0] imem_addr;
    logic [c_XLEN-1:0] imem_wd;
    // Core control and status
    logic              core_rst;
    logic              core_en;
    logic [2:0]        state;
    logic              halted;
    logic [2:0]        halt_cause;
    logic [CYC_W-1:0]  cycle_cnt;

    // Host / environment side
    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        output cmd_run, cmd_step, cmd_halt,
        output pc, instr,
`ifdef CORE_RUN_CTRL_BKPT_EN
        output bkpt_en, bkpt_addr,
`endif
        input  ld_ready, imem_we, imem_addr, imem_wd,
        input  core_rst, core_en, state, halted, halt_cause, cycle_cnt
    );

    // Sequencer side
    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        input  cmd_run, cmd_step, cmd_halt,
        input  pc, instr,
`ifdef CORE_RUN_CTRL_BKPT_EN
        input  bkpt_en, bkpt_addr,
`endif
        output ld_ready, imem_we, imem_addr, imem_wd,
        output core_rst, core_en, state, halted, halt_cause, cycle_cnt
    );

endinterface

`default_nettype wire

// File: rtl/core_run_ctrl_sat_counter.sv
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter with synchronous clear and increment enable that
//             sticks at all-ones instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; clear wins over increment, hold once saturated
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/core_run_ctrl.sv
// ============================================================================
//  Module   : core_run_ctrl
//  Purpose  : Run-control sequencer for the single-cycle RV32I core. Holds the
//             core in reset while the host loads instruction memory, then
//             runs, single-steps or halts it through a clock-enable, stopping
//             on EBREAK, a host halt, or (with CORE_RUN_CTRL_BKPT_EN defined)
//             a PC breakpoint.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CYC_W      = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    core_run_ctrl_if.slave bus
);

    localparam int               c_RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RCW-1:0] c_RST_LOAD = c_RCW'(RST_CYCLES - 1);

    run_state_t       r_state;
    run_state_t       w_state_nxt;
    halt_cause_t      r_halt_cause;
    halt_cause_t      w_cause_nxt;
    logic [c_RCW-1:0] r_rst_cnt;
    logic [c_RCW-1:0] w_rst_cnt_nxt;
    logic             r_first;
    logic             w_ld_ready;
    logic             w_ld_fire;
    logic             w_ebreak_hit;
    logic             w_bkpt_hit;
    logic             w_stop;
    logic             w_core_en;
    logic             w_cnt_clr;
    logic [CYC_W-1:0] w_cycle_cnt;

    // ------------------------------------------------------------------
    // Stop detection
    // ------------------------------------------------------------------
    assign w_ebreak_hit = is_ebreak(bus.instr);

`ifdef CORE_RUN_CTRL_BKPT_EN
    assign w_bkpt_hit = bus.bkpt_en && (bus.pc == bus.bkpt_addr);
`else
    // Without breakpoints the PC is only observed, never compared
    logic w_unused_pc;
    assign w_unused_pc = ^bus.pc;
    assign w_bkpt_hit  = 1'b0;
`endif

    // The first RUN cycle after HALTED ignores stops so a resume from
    // EBREAK/breakpoint moves past the stopping instruction.
    assign w_stop    = (r_state == ST_RUN) && !r_first && (w_ebreak_hit || w_bkpt_hit);
    assign w_core_en = ((r_state == ST_RUN) && !w_stop) || (r_state == ST_STEP);

    // ------------------------------------------------------------------
    // Load port: writes pass straight through to instruction memory
    // ------------------------------------------------------------------
    assign w_ld_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_ld_fire  = bus.ld_valid && w_ld_ready;

    // ------------------------------------------------------------------
    // State register, halt cause, reset-hold counter and resume flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_halt_cause <= CAUSE_RESET;
            r_rst_cnt    <= '0;
            r_first      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_cause_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_first      <= (r_state == ST_HALTED);
        end
    end

    // Next-state, cause and reset-hold countdown
    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_halt_cause;
        w_rst_cnt_nxt = r_rst_cnt;
        w_cnt_clr     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ld_fire) begin
                    w_state_nxt = bus.ld_last ? ST_CRST : ST_LOAD;
                end else if (bus.cmd_run) begin
                    w_state_nxt = ST_CRST;
                end
            end
            ST_LOAD: begin
                if (w_ld_fire && bus.ld_last) begin
                    w_state_nxt = ST_CRST;
                end
            end
            ST_CRST: begin
                if (r_rst_cnt == '0) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_RESET;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - c_RCW'(1);
                end
            end
            ST_HALTED: begin
                if (bus.cmd_step) begin
                    w_state_nxt = ST_STEP;
                end else if (bus.cmd_run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = w_ebreak_hit ? CAUSE_EBREAK : CAUSE_BKPT;
                end else if (bus.cmd_halt) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_HOST;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_HALTED;
                w_cause_nxt = CAUSE_STEP;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Entering CRST arms the hold countdown and restarts the cycle count
        if ((w_state_nxt == ST_CRST) && (r_state != ST_CRST)) begin
            w_rst_cnt_nxt = c_RST_LOAD;
            w_cnt_clr     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Executed-cycle counter
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CYC_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_cnt_clr),
        .inc   (w_core_en),
        .count (w_cycle_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ld_ready   = w_ld_ready;
    assign bus.imem_we    = w_ld_fire;
    assign bus.imem_addr  = w_ld_fire ? bus.ld_addr : '0;
    assign bus.imem_wd    = w_ld_fire ? bus.ld_data : '0;
    assign bus.core_rst   = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_CRST);
    assign bus.core_en    = w_core_en;
    assign bus.state      = r_state;
    assign bus.halted     = (r_state == ST_HALTED);
    assign bus.halt_cause = r_halt_cause;
    assign bus.cycle_cnt  = w_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
// ============================================================================
//  Module   : tb_core_run_ctrl
//  Purpose  : Scoreboard bench for core_run_ctrl with a tiny PC/imem model of
//             the core. Breakpoint section active with CORE_RUN_CTRL_BKPT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_run_ctrl;

    localparam int RST_CYC = 2;
    localparam int CW      = 4;

    localparam logic [31:0] ADDI1  = 32'h0010_8093;
    localparam logic [31:0] ADDI2  = 32'h0011_0113;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]    cause;
        logic [CW-1:0] cnt;
        logic [31:0]   pc;
    } halt_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_run_ctrl_if #(.CYC_W(CW)) bus ();

    core_run_ctrl #(
        .RST_CYCLES (RST_CYC),
        .CYC_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core environment: instruction memory and a PC that advances when enabled
    logic [31:0] mem [0:7];
    logic [31:0] tb_pc;

    always @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_addr[4:2]] <= bus.imem_wd;
        if (bus.core_rst)     tb_pc <= 32'h0;
        else if (bus.core_en) tb_pc <= tb_pc + 32'd4;
    end

    assign bus.pc    = tb_pc;
    assign bus.instr = (tb_pc < 32'd32) ? mem[tb_pc[4:2]] : NOP;

    // Scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] wr_q [$];
    halt_exp_t   halt_q [$];
    int          en_cnt   = 0;
    int          crst_run = 0;
    logic        prev_halted = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_halt(input logic [2:0] c, input logic [CW-1:0] n, input logic [31:0] p);
        halt_exp_t e;
        e.cause = c;
        e.cnt   = n;
        e.pc    = p;
        halt_q.push_back(e);
    endfunction

    // Monitor: compares imem writes, CRST duration and each HALTED entry
    always @(negedge clk) begin
        logic [63:0] w;
        halt_exp_t   e;
        if (bus.imem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("imem_we_unexpected", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                check("imem_addr", bus.imem_addr, w[63:32]);
                check("imem_wd", bus.imem_wd, w[31:0]);
            end
        end
        if (bus.core_en === 1'b1) en_cnt++;
        if (bus.state === 3'd2) begin
            crst_run++;
        end else if (crst_run != 0) begin
            check("crst_len", 32'(crst_run), 32'(RST_CYC));
            crst_run = 0;
        end
        if (bus.halted === 1'b1 && prev_halted !== 1'b1) begin
            if (halt_q.size() == 0) begin
                check("halt_unexpected", 32'd1, 32'd0);
            end else begin
                e = halt_q.pop_front();
                check("halt_cause", 32'(bus.halt_cause), 32'(e.cause));
                check("halt_cycle_cnt", 32'(bus.cycle_cnt), 32'(e.cnt));
                check("halt_pc", tb_pc, e.pc);
            end
        end
        prev_halted = bus.halted;
    end

    task automatic cmd(input logic r, input logic s, input logic h);
        @(posedge clk);
        #1;
        bus.cmd_run  = r;
        bus.cmd_step = s;
        bus.cmd_halt = h;
        @(posedge clk);
        #1;
        bus.cmd_run  = 1'b0;
        bus.cmd_step = 1'b0;
        bus.cmd_halt = 1'b0;
    endtask

    // Resume and execute exactly n cycles, ending with cmd_halt+cmd_run together
    task automatic run_for(input int n);
        @(posedge clk);
        #1 bus.cmd_run = 1'b1;
        @(posedge clk);
        #1 bus.cmd_run = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
        bus.cmd_halt = 1'b1;
        bus.cmd_run  = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_halt = 1'b0;
        bus.cmd_run  = 1'b0;
    endtask

    task automatic wait_halt();
        int k = 0;
        while (bus.halted !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("halt_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] prog [0:7];
        int          e0;
        prog = '{ADDI1, ADDI1, ADDI1, EBRK, ADDI2, ADDI2, ADDI2, ADDI2};

        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.cmd_run  = 1'b0;
        bus.cmd_step = 1'b0;
        bus.cmd_halt = 1'b0;
`ifdef CORE_RUN_CTRL_BKPT_EN
        bus.bkpt_en   = 1'b0;
        bus.bkpt_addr = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_core_rst", 32'(bus.core_rst), 32'd1);
        check("rst_core_en", 32'(bus.core_en), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_halt_cause", 32'(bus.halt_cause), 32'd0);
        check("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);

        // Back-to-back program load, last word flagged
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 32'(i * 4);
            bus.ld_data  = prog[i];
            bus.ld_last  = (i == 7);
            wr_q.push_back({32'(i * 4), prog[i]});
        end
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("crst_ld_ready", 32'(bus.ld_ready), 32'd0);
        push_halt(3'd0, 4'd0, 32'h0);
        wait_halt();

        // Run to EBREAK: three addi execute, EBREAK does not
        e0 = en_cnt;
        push_halt(3'd2, 4'd3, 32'hC);
        cmd(1'b1, 1'b0, 1'b0);
        wait_halt();
        check("run_en_cycles", 32'(en_cnt - e0), 32'd3);

        // Host halt while already halted has no effect
        cmd(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("halt_in_halted", 32'(bus.state), 32'd3);

        // Two single steps; the first passes over EBREAK
        e0 = en_cnt;
        push_halt(3'd4, 4'd4, 32'h10);
        cmd(1'b0, 1'b1, 1'b0);
        wait_halt();
        push_halt(3'd4, 4'd5, 32'h14);
        cmd(1'b1, 1'b1, 1'b0);
        wait_halt();
        check("step_en_cycles", 32'(en_cnt - e0), 32'd2);

        // Host halt together with run: halt wins, that instruction executes
        push_halt(3'd1, 4'd7, 32'h1C);
        run_for(2);
        wait_halt();

`ifdef CORE_RUN_CTRL_BKPT_EN
        // Breakpoint stops before 0x24; resume executes it
        bus.bkpt_en   = 1'b1;
        bus.bkpt_addr = 32'h24;
        push_halt(3'd3, 4'd9, 32'h24);
        cmd(1'b1, 1'b0, 1'b0);
        wait_halt();
        push_halt(3'd1, 4'd12, 32'h30);
        run_for(3);
        wait_halt();
        bus.bkpt_en = 1'b0;
        // Saturation
        push_halt(3'd1, 4'hF, 32'h60);
        run_for(12);
        wait_halt();
`else
        // Saturation: 7 + 12 exceeds the 4-bit range
        push_halt(3'd1, 4'hF, 32'h4C);
        run_for(12);
        wait_halt();
`endif
        @(negedge clk);
        check("sat_hold", 32'(bus.cycle_cnt), 32'hF);

        // Reset in the middle of RUN
        @(posedge clk);
        #1 bus.cmd_run = 1'b1;
        @(posedge clk);
        #1 bus.cmd_run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(bus.state), 32'd0);
        check("midrst_core_rst", 32'(bus.core_rst), 32'd1);
        check("midrst_core_en", 32'(bus.core_en), 32'd0);
        check("midrst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);

        // Run from IDLE uses the resident program
        push_halt(3'd0, 4'd0, 32'h0);
        cmd(1'b1, 1'b0, 1'b0);
        wait_halt();
        push_halt(3'd2, 4'd3, 32'hC);
        cmd(1'b1, 1'b0, 1'b0);
        wait_halt();

        repeat (2) @(negedge clk);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("halt_q_drained", 32'(halt_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
